// File: rtl/jtframe_sram_pkg.sv
// Shared definitions for the byte-wide SRAM arbiter: access-sequencer states
// and the default strobe width.
package jtframe_sram_pkg;

    localparam int WAIT_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        GAP,
        HI,
        DONE
    } state_t;

endpackage

// File: rtl/jtframe_sram_arb_if.sv
// Word-wide request/ack port of the SRAM arbiter; one instance per requester.
interface jtframe_sram_arb_if #(
    parameter int AW = 20
);

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   din;
    logic [15:0]   dout;
    logic          ack;

    modport master (output req, we, addr, din, input  dout, ack);
    modport slave  (input  req, we, addr, din, output dout, ack);

endinterface

// File: rtl/jtframe_sram_arb.sv
// Two-port round-robin arbiter that splits 16-bit word accesses into two
// byte accesses on an 8-bit asynchronous SRAM.
module jtframe_sram_arb
    import jtframe_sram_pkg::*;
#(
    parameter int WAIT = WAIT_DEFAULT,
    parameter int AW   = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    jtframe_sram_arb_if.slave p0,
    jtframe_sram_arb_if.slave p1,
    output logic [AW:0]       sram_addr,
    output logic [7:0]        sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_in,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    localparam logic [2:0] CNT_LAST = 3'(WAIT - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [2:0]    r_cnt;
    logic          r_port;
    logic          r_last;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_din;
    logic [7:0]    r_lo;
    logic [15:0]   r_dout0;
    logic [15:0]   r_dout1;

    logic w_any_req;
    logic w_gnt_p1;
    logic w_grant;
    logic w_cnt_last;
    logic w_byte_sel;

    // On a tie the port that did not win last time is served.
    assign w_any_req  = p0.req | p1.req;
    assign w_gnt_p1   = p1.req & (~p0.req | ~r_last);
    assign w_grant    = (r_state == IDLE) & w_any_req;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            r_state <= w_next_state;
            if ((r_state == LO || r_state == HI) && !w_cnt_last)
                r_cnt <= r_cnt + 3'd1;
            else
                r_cnt <= '0;
        end
    end

    always_comb begin
        // NOTE: defaulting before the case keeps this purely combinational (no latch).
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req)  w_next_state = LO;
            LO:      if (w_cnt_last) w_next_state = GAP;
            GAP:                     w_next_state = HI;
            HI:      if (w_cnt_last) w_next_state = DONE;
            DONE:                    w_next_state = IDLE;
            default:                 w_next_state = IDLE;
        endcase
    end

    // Write strobe releases one cycle before the byte ends to give data hold.
    always_comb begin
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_dq_oe = 1'b0;
        w_byte_sel = 1'b0;
        case (r_state)
            LO: begin
                sram_dq_oe = r_we;
                sram_we_n  = ~r_we | w_cnt_last;
                sram_oe_n  = r_we;
            end
            GAP: begin
                sram_dq_oe = r_we;
                w_byte_sel = 1'b1;
            end
            HI: begin
                sram_dq_oe = r_we;
                sram_we_n  = ~r_we | w_cnt_last;
                sram_oe_n  = r_we;
                w_byte_sel = 1'b1;
            end
            DONE:    w_byte_sel = 1'b1;
            default: ;
        endcase
    end

    assign sram_addr   = {r_addr, w_byte_sel};
    assign sram_dq_out = w_byte_sel ? r_din[15:8] : r_din[7:0];
    assign p0.ack      = (r_state == DONE) & ~r_port;
    assign p1.ack      = (r_state == DONE) &  r_port;
    assign p0.dout     = r_dout0;
    assign p1.dout     = r_dout1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_port  <= 1'b0;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_lo    <= '0;
            r_dout0 <= '0;
            r_dout1 <= '0;
        end else begin
            if (w_grant) begin
                r_port <= w_gnt_p1;
                r_last <= w_gnt_p1;
                r_we   <= w_gnt_p1 ? p1.we   : p0.we;
                r_addr <= w_gnt_p1 ? p1.addr : p0.addr;
                r_din  <= w_gnt_p1 ? p1.din  : p0.din;
            end
            if (r_state == LO && w_cnt_last && !r_we)
                r_lo <= sram_dq_in;
            if (r_state == HI && w_cnt_last && !r_we) begin
                if (r_port) r_dout1 <= {sram_dq_in, r_lo};
                else        r_dout0 <= {sram_dq_in, r_lo};
            end
        end
    end

endmodule

// File: tb/tb_jtframe_sram_arb.sv
// Bench for jtframe_sram_arb: directed table, corner-case sequences and random
// traffic checked cycle by cycle against a phase-count model and a byte SRAM.
module tb_jtframe_sram_arb;

    localparam int AW = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    jtframe_sram_arb_if #(.AW(AW)) p0a ();
    jtframe_sram_arb_if #(.AW(AW)) p1a ();
    jtframe_sram_arb_if #(.AW(AW)) p0b ();
    jtframe_sram_arb_if #(.AW(AW)) p1b ();

    logic [AW:0] addr_a, addr_b;
    logic [7:0]  dq_a, dq_b;
    logic        oe_a, oe_b, we_a, we_b, rd_a, rd_b;
    logic [7:0]  pad_in = 8'h00;

    bit            tb_req  [2];
    bit            tb_we   [2];
    logic [AW-1:0] tb_addr [2];
    logic [15:0]   tb_din  [2];

    assign p0a.req = tb_req[0];  assign p0a.we = tb_we[0];
    assign p0a.addr = tb_addr[0]; assign p0a.din = tb_din[0];
    assign p1a.req = tb_req[1];  assign p1a.we = tb_we[1];
    assign p1a.addr = tb_addr[1]; assign p1a.din = tb_din[1];
    assign p0b.req = tb_req[0];  assign p0b.we = tb_we[0];
    assign p0b.addr = tb_addr[0]; assign p0b.din = tb_din[0];
    assign p1b.req = tb_req[1];  assign p1b.we = tb_we[1];
    assign p1b.addr = tb_addr[1]; assign p1b.din = tb_din[1];

    jtframe_sram_arb #(.WAIT(2), .AW(AW)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .p0(p0a), .p1(p1a),
        .sram_addr(addr_a), .sram_dq_out(dq_a), .sram_dq_oe(oe_a),
        .sram_dq_in(pad_in), .sram_we_n(we_a), .sram_oe_n(rd_a)
    );

    jtframe_sram_arb #(.WAIT(1), .AW(AW)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n), .p0(p0b), .p1(p1b),
        .sram_addr(addr_b), .sram_dq_out(dq_b), .sram_dq_oe(oe_b),
        .sram_dq_in(pad_in), .sram_we_n(we_b), .sram_oe_n(rd_b)
    );

    bit dut_sel = 1'b0;
    logic [AW:0] o_addr;
    logic [7:0]  o_dq_out;
    logic        o_dq_oe, o_we_n, o_oe_n, o_ack0, o_ack1;
    logic [15:0] o_dout0, o_dout1;

    assign o_addr   = dut_sel ? addr_b  : addr_a;
    assign o_dq_out = dut_sel ? dq_b    : dq_a;
    assign o_dq_oe  = dut_sel ? oe_b    : oe_a;
    assign o_we_n   = dut_sel ? we_b    : we_a;
    assign o_oe_n   = dut_sel ? rd_b    : rd_a;
    assign o_ack0   = dut_sel ? p0b.ack : p0a.ack;
    assign o_ack1   = dut_sel ? p1b.ack : p1a.ack;
    assign o_dout0  = dut_sel ? p0b.dout : p0a.dout;
    assign o_dout1  = dut_sel ? p1b.dout : p1a.dout;

    // Reference model: m_k counts cycles since the grant (0 = idle).
    int            W = 2;
    int            m_k;
    bit            m_port, m_last, m_we;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_din;
    logic [15:0]   m_dout [2];
    logic [7:0]    mem     [logic [AW:0]];
    logic [15:0]   ref_mem [logic [AW-1:0]];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic [15:0]   exp_rd;
        int            exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pad_rd(input logic [AW:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'hEE;
    endfunction

    task automatic model_reset();
        m_k = 0; m_port = 1'b0; m_last = 1'b1; m_we = 1'b0;
        m_addr = '0; m_din = '0;
        m_dout[0] = '0; m_dout[1] = '0;
    endtask

    task automatic model_edge();
        bit p;
        if (m_k == 0) begin
            if (tb_req[0] || tb_req[1]) begin
                p = (tb_req[0] && tb_req[1]) ? ~m_last : tb_req[1];
                m_port = p; m_last = p;
                m_we = tb_we[p]; m_addr = tb_addr[p]; m_din = tb_din[p];
                m_k = 1;
            end
        end else if (m_k == 2 * W + 2) begin
            m_k = 0;
        end else begin
            m_k++;
            if (m_k == 2 * W + 2) begin
                if (m_we) ref_mem[m_addr] = m_din;
                else m_dout[m_port] = ref_mem.exists(m_addr) ? ref_mem[m_addr] : 16'hEEEE;
            end
        end
    endtask

    task automatic check_outputs();
        bit sel, acc, chk_a;
        int j;
        logic e_we_n, e_oe_n, e_oe, e_a0, e_a1;
        sel = 0; acc = 0; chk_a = 0; j = 0;
        e_we_n = 1'b1; e_oe_n = 1'b1; e_oe = 1'b0; e_a0 = 1'b0; e_a1 = 1'b0;
        if (m_k >= 1 && m_k <= W) begin
            acc = 1; j = m_k;
        end else if (m_k == W + 1) begin
            sel = 1; chk_a = 1; e_oe = m_we;
        end else if (m_k >= W + 2 && m_k <= 2 * W + 1) begin
            acc = 1; sel = 1; j = m_k - W - 1;
        end else if (m_k == 2 * W + 2) begin
            e_a0 = ~m_port; e_a1 = m_port;
        end
        if (acc) begin
            chk_a = 1; e_oe = m_we;
            if (m_we) e_we_n = (j == W);
            else      e_oe_n = 1'b0;
        end
        check("strobes", {o_we_n, o_oe_n, o_dq_oe, o_ack0, o_ack1},
              {e_we_n, e_oe_n, e_oe, e_a0, e_a1});
        if (chk_a) check("addr", o_addr, {m_addr, sel});
        if (acc && m_we) check("dq_out", o_dq_out, sel ? m_din[15:8] : m_din[7:0]);
        check("dout", {o_dout0, o_dout1}, {m_dout[0], m_dout[1]});
    endtask

    // One clock: SRAM pad write before the edge, model step, check mid-cycle.
    task automatic cycle();
        if (!o_we_n && o_dq_oe) mem[o_addr] = o_dq_out;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        pad_in = !o_oe_n ? pad_rd(o_addr) : 8'h00;
        check_outputs();
    endtask

    task automatic do_reset(input bit sel);
        tb_req[0] = 0; tb_req[1] = 0;
        rst_n   = 1'b0;
        dut_sel = sel;
        #1;
        W = sel ? 1 : 2;
        mem.delete(); ref_mem.delete();
        model_reset();
        check("rst_strobes", {o_we_n, o_oe_n, o_dq_oe, o_ack0, o_ack1}, 5'b11000);
        check("rst_addr", o_addr, 0);
        check("rst_dq_out", o_dq_out, 0);
        check("rst_dout", {o_dout0, o_dout1}, 0);
        pad_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_txn(input bit p, input bit we, input logic [AW-1:0] a,
                           input logic [15:0] d, output int lat, output logic [15:0] rd);
        int  n;
        bit  got;
        tb_req[p] = 1; tb_we[p] = we; tb_addr[p] = a; tb_din[p] = d;
        n = 0; got = 0;
        while (!got && n < 30) begin
            cycle();
            n++;
            if (p ? o_ack1 : o_ack0) got = 1;
        end
        tb_req[p] = 0;
        lat = got ? n : -1;
        rd  = p ? o_dout1 : o_dout0;
        cycle();
    endtask

    task automatic new_req(input int p);
        tb_req[p]  = 1;
        tb_we[p]   = 1'($urandom_range(0, 1));
        tb_addr[p] = AW'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? 20'hFFFF0 : 20'h0);
        tb_din[p]  = 16'($urandom);
    endtask

    initial begin
        vec_t        vecs [7];
        int          lat, n_ack, n;
        logic [15:0] rd;
        bit          got;
        int          ack_port [$];
        int          ack_cyc  [$];

        vecs[0] = '{0, 1, 20'h00010, 16'hA55A, 16'h0000, 6};
        vecs[1] = '{1, 0, 20'h00010, 16'h0000, 16'hA55A, 6};
        vecs[2] = '{1, 1, 20'hFFFFF, 16'h1234, 16'h0000, 6};
        vecs[3] = '{0, 0, 20'hFFFFF, 16'h0000, 16'h1234, 6};
        vecs[4] = '{0, 1, 20'h00000, 16'hFFFF, 16'h0000, 6};
        vecs[5] = '{1, 0, 20'h00000, 16'h0000, 16'hFFFF, 6};
        vecs[6] = '{0, 0, 20'h00010, 16'h0000, 16'hA55A, 6};

        for (int p = 0; p < 2; p++) begin
            tb_req[p] = 0; tb_we[p] = 0; tb_addr[p] = '0; tb_din[p] = '0;
        end
        #3;
        do_reset(0);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].din, lat, rd);
            check("latency", lat, vecs[i].exp_lat);
            if (!vecs[i].we) check("rdata", rd, vecs[i].exp_rd);
            if (i == 0) begin
                check("byte_lo", pad_rd(21'h00020), 8'h5A);
                check("byte_hi", pad_rd(21'h00021), 8'hA5);
            end
        end

        // Requester drops req right after being granted; the ack must still come.
        tb_req[1] = 1; tb_we[1] = 0; tb_addr[1] = 20'h00010;
        cycle();
        tb_req[1] = 0;
        n_ack = 0;
        repeat (12) begin
            cycle();
            if (o_ack1) n_ack++;
        end
        check("drop_acks", n_ack, 1);

        for (int c = 0; c < 400; c++) begin
            cycle();
            for (int p = 0; p < 2; p++) begin
                if (tb_req[p]) begin
                    if (m_k == 2 * W + 2 && m_port == 1'(p)) begin
                        if ($urandom_range(0, 1) == 0) tb_req[p] = 0;
                        else new_req(p);
                    end else if (m_k >= 1 && m_k <= 2 * W + 1 && m_port == 1'(p) &&
                                 $urandom_range(0, 7) == 0) begin
                        tb_req[p] = 0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    new_req(p);
                end
            end
        end
        tb_req[0] = 0; tb_req[1] = 0;
        repeat (2 * W + 4) cycle();

        // Reset pulse in the first HI cycle of a write.
        tb_req[0] = 1; tb_we[0] = 1; tb_addr[0] = 20'h00040; tb_din[0] = 16'h5AA5;
        got = 0; n = 0;
        while (!got && n < 20) begin
            cycle();
            n++;
            if (o_addr[0] && !o_we_n) got = 1;
        end
        check("hi_reached", got, 1);
        do_reset(0);
        n_ack = 0;
        repeat (3) begin
            cycle();
            if (o_ack0 || o_ack1) n_ack++;
        end
        check("abort_no_ack", n_ack, 0);

        // Both ports hold req continuously: grants must alternate starting at p0.
        tb_req[0] = 1; tb_we[0] = 1; tb_addr[0] = 20'h00100; tb_din[0] = 16'hBEEF;
        tb_req[1] = 1; tb_we[1] = 0; tb_addr[1] = 20'h00100;
        n = 0;
        while (ack_port.size() < 4 && n < 60) begin
            cycle();
            n++;
            if (o_ack0) begin ack_port.push_back(0); ack_cyc.push_back(n); end
            if (o_ack1) begin ack_port.push_back(1); ack_cyc.push_back(n); end
        end
        tb_req[0] = 0; tb_req[1] = 0;
        check("rr_count", ack_port.size(), 4);
        for (int i = 0; i < ack_port.size(); i++) check("rr_order", ack_port[i], i % 2);
        for (int i = 1; i < ack_cyc.size(); i++) check("rr_gap", ack_cyc[i] - ack_cyc[i-1], 7);
        cycle();
        cycle();

        // WAIT=1 instance at the top of the address space.
        do_reset(1);
        run_txn(0, 1, 20'hFFFFF, 16'h1234, lat, rd);
        check("w1_latency", lat, 4);
        run_txn(1, 1, 20'h00000, 16'h8001, lat, rd);
        check("w1_latency_p1", lat, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
